// File: rtl/board_io_adapter.sv
// Board-side I/O adapter: button synchroniser/debouncer, colour depth reduction and sync re-timing.
// Define BOARD_IO_DITHER_EN to add 2x2 ordered dithering to the colour reduction.
module board_io_adapter #(
  parameter int unsigned IN_BITS         = 4,
  parameter int unsigned OUT_BITS        = 2,
  parameter int unsigned N_BTN           = 3,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_BTN-1:0]    btn_raw,
  output logic [N_BTN-1:0]    btn_level,
  output logic [N_BTN-1:0]    btn_press,
  input  logic [IN_BITS-1:0]  in_r,
  input  logic [IN_BITS-1:0]  in_g,
  input  logic [IN_BITS-1:0]  in_b,
  input  logic                in_hs,
  input  logic                in_vs,
  output logic [OUT_BITS-1:0] out_r,
  output logic [OUT_BITS-1:0] out_g,
  output logic [OUT_BITS-1:0] out_b,
  output logic                out_hs,
  output logic                out_vs,
  output logic                frame_start
);
  localparam int unsigned D  = IN_BITS - OUT_BITS;
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  if (OUT_BITS < 1 || OUT_BITS > IN_BITS) begin : g_bad_bits
    $error("board_io_adapter: OUT_BITS must satisfy 1 <= OUT_BITS <= IN_BITS");
  end
  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2) begin : g_bad_btn
    $error("board_io_adapter: SYNC_STAGES and DEBOUNCE_CYCLES must be >= 2");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   lvl_q, lvl_d, prs_q, prs_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw[i]};
      cnt_d  = cnt_q;
      lvl_d  = lvl_q;
      prs_d  = 1'b0;
      if (s == lvl_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        lvl_d = s;
        cnt_d = '0;
        prs_d = s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q <= '0;
        cnt_q  <= '0;
        lvl_q  <= 1'b0;
        prs_q  <= 1'b0;
      end else begin
        sync_q <= sync_d;
        cnt_q  <= cnt_d;
        lvl_q  <= lvl_d;
        prs_q  <= prs_d;
      end
    end

    assign btn_level[i] = lvl_q;
    assign btn_press[i] = prs_q;
  end

  logic [OUT_BITS-1:0] r_q, g_q, b_q, r_d, g_d, b_d;
  logic                hs_q, vs_q, fs_q;
  logic                hs_fall, vs_fall;

  // The registered syncs double as the one-cycle delayed copies for edge detection.
  assign hs_fall = hs_q & ~in_hs;
  assign vs_fall = vs_q & ~in_vs;

  if (D == 0) begin : g_pass
    assign r_d = in_r;
    assign g_d = in_g;
    assign b_d = in_b;
  end else begin : g_reduce
`ifdef BOARD_IO_DITHER_EN
    logic         xp_q, xp_d, yp_q, yp_d;
    logic [1:0]   t;
    logic [D-1:0] thr;

    function automatic logic [OUT_BITS-1:0] dither(input logic [IN_BITS-1:0] v,
                                                   input logic [D-1:0]       th);
      logic [OUT_BITS-1:0] q;
      logic [D-1:0]        e;
      q = v[IN_BITS-1 -: OUT_BITS];
      e = v[D-1:0];
      return (e > th && q != '1) ? q + OUT_BITS'(1) : q;
    endfunction

    always_comb begin
      xp_d = hs_fall ? 1'b0 : ~xp_q;
      yp_d = vs_fall ? 1'b0 : (yp_q ^ hs_fall);
      case ({yp_q, xp_q})
        2'b00:   t = 2'd0;
        2'b01:   t = 2'd2;
        2'b10:   t = 2'd3;
        default: t = 2'd1;
      endcase
    end

    if (D == 1) begin : g_thr1
      assign thr = t[1];
    end else begin : g_thrn
      assign thr = D'(t) << (D - 2);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        xp_q <= 1'b0;
        yp_q <= 1'b0;
      end else begin
        xp_q <= xp_d;
        yp_q <= yp_d;
      end
    end

    assign r_d = dither(in_r, thr);
    assign g_d = dither(in_g, thr);
    assign b_d = dither(in_b, thr);
`else
    logic unused_residual;
    assign unused_residual = ^{in_r[D-1:0], in_g[D-1:0], in_b[D-1:0]};
    assign r_d = in_r[IN_BITS-1 -: OUT_BITS];
    assign g_d = in_g[IN_BITS-1 -: OUT_BITS];
    assign b_d = in_b[IN_BITS-1 -: OUT_BITS];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      fs_q <= 1'b0;
    end else begin
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
      hs_q <= in_hs;
      vs_q <= in_vs;
      fs_q <= vs_fall;
    end
  end

  assign out_r       = r_q;
  assign out_g       = g_q;
  assign out_b       = b_q;
  assign out_hs      = hs_q;
  assign out_vs      = vs_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_board_io_adapter.sv
// Self-checking bench for board_io_adapter against a behavioural model (button run lengths, pixel phase counters).
`timescale 1ns/1ps
module tb_board_io_adapter;
  localparam int unsigned IB = 4, OB = 2, NB = 3, SS = 2, DEB = 8;
`ifdef BOARD_IO_DITHER_EN
  localparam bit DITHER = 1'b1;
`else
  localparam bit DITHER = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level, btn_press;
  logic [IB-1:0] in_r = '0, in_g = '0, in_b = '0;
  logic          in_hs = 1'b1, in_vs = 1'b1;
  logic [OB-1:0] out_r, out_g, out_b;
  logic          out_hs, out_vs, frame_start;

  always #5 clk = ~clk;

  board_io_adapter #(.IN_BITS(IB), .OUT_BITS(OB), .N_BTN(NB), .SYNC_STAGES(SS),
                     .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level), .btn_press(btn_press),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_hs(in_hs), .in_vs(in_vs),
    .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_hs(out_hs), .out_vs(out_vs),
    .frame_start(frame_start));

  // Reference model state
  logic [NB-1:0] raw_q[$];
  int            run[NB];
  logic [NB-1:0] last_s, lvl_m, prs_m;
  logic [OB-1:0] e_r, e_g, e_b;
  logic          e_hs, e_vs, e_fs;
  int            cyc_hs, lines_vs;
  logic          prev_hs, prev_vs;
  int            checks = 0, errors = 0;

  logic [14:0] obs, expv;
  assign obs  = {btn_level, btn_press, out_r, out_g, out_b, out_hs, out_vs, frame_start};
  assign expv = {lvl_m, prs_m, e_r, e_g, e_b, e_hs, e_vs, e_fs};

  function automatic logic [OB-1:0] reduce(input logic [IB-1:0] v, input int x, input int y);
    int d, q, e, thr;
    d = int'(IB) - int'(OB);
    q = int'(v) >> d;
    e = int'(v) % (1 << d);
    if (y == 0) thr = (x == 0) ? 0 : 2;
    else        thr = (x == 0) ? 3 : 1;
    thr = (d >= 2) ? (thr << (d - 2)) : (thr >> 1);
    if (DITHER && d > 0 && e > thr && q < (1 << OB) - 1) q = q + 1;
    return OB'(q);
  endfunction

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic tick();
    logic [NB-1:0] s;
    int   x, y;
    logic hsf, vsf;
    if (rst) begin
      raw_q.delete();
      for (int c = 0; c < NB; c++) run[c] = 0;
      last_s = '0; lvl_m = '0; prs_m = '0;
      e_r = '0; e_g = '0; e_b = '0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
      cyc_hs = 0; lines_vs = 0; prev_hs = 1'b1; prev_vs = 1'b1;
    end else begin
      raw_q.push_back(btn_raw);
      s = (raw_q.size() > int'(SS)) ? raw_q[0] : '0;
      if (raw_q.size() > int'(SS)) void'(raw_q.pop_front());
      prs_m = '0;
      for (int c = 0; c < NB; c++) begin
        run[c] = (s[c] == last_s[c]) ? run[c] + 1 : 1;
        if (s[c] != lvl_m[c] && run[c] >= int'(DEB)) begin
          lvl_m[c] = s[c];
          prs_m[c] = s[c];
        end
      end
      last_s = s;
      x = cyc_hs % 2;
      y = lines_vs % 2;
      e_r = reduce(in_r, x, y);
      e_g = reduce(in_g, x, y);
      e_b = reduce(in_b, x, y);
      hsf = prev_hs & ~in_hs;
      vsf = prev_vs & ~in_vs;
      e_hs = in_hs; e_vs = in_vs; e_fs = vsf;
      cyc_hs   = hsf ? 0 : cyc_hs + 1;
      lines_vs = vsf ? 0 : lines_vs + (hsf ? 1 : 0);
      prev_hs = in_hs; prev_vs = in_vs;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      btn_raw = NB'($urandom); in_r = IB'($urandom); in_g = IB'($urandom); in_b = IB'($urandom);
      in_hs = 1'($urandom); in_vs = 1'($urandom);
      tick();
      checks++;
      if (obs !== {3'b0, 3'b0, 6'b0, 1'b1, 1'b1, 1'b0}) begin
        errors++; $display("FAIL reset cyc %0d: got %h want %h", i, obs, {9'b0, 6'b110});
      end
    end
    rst = 1'b0; btn_raw = '0; in_r = '0; in_g = '0; in_b = '0; in_hs = 1'b1; in_vs = 1'b1;
    tick();
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL post_reset: got %h want %h", obs, expv); end
  endtask

  task automatic test_debounce();
    int lat, np;
    for (int i = 0; i < 17; i++) begin
      btn_raw[1] = (i < 5);
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL glitch cyc %0d: got %h want %h", i, obs, expv); end
    end
    checks++;
    if (btn_level[1] !== 1'b0) begin errors++; $display("FAIL glitch_rejected: got %b want 0", btn_level[1]); end
    lat = -1; np = 0; btn_raw[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL rise cyc %0d: got %h want %h", i, obs, expv); end
      if (btn_press[1] === 1'b1) np++;
      if (lat < 0 && btn_level[1] === 1'b1) lat = i + 1;
    end
    checks++;
    if (lat != int'(SS + DEB)) begin errors++; $display("FAIL rise_latency: got %0d want %0d", lat, SS + DEB); end
    checks++;
    if (np != 1) begin errors++; $display("FAIL press_count: got %0d want 1", np); end
    lat = -1; np = 0; btn_raw[1] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL fall cyc %0d: got %h want %h", i, obs, expv); end
      if (btn_press[1] === 1'b1) np++;
      if (lat < 0 && btn_level[1] === 1'b0) lat = i + 1;
    end
    checks++;
    if (lat != int'(SS + DEB)) begin errors++; $display("FAIL fall_latency: got %0d want %0d", lat, SS + DEB); end
    checks++;
    if (np != 0) begin errors++; $display("FAIL release_press: got %0d want 0", np); end
  endtask

  task automatic test_video_random();
    for (int i = 0; i < 300; i++) begin
      in_r = ($urandom_range(0, 3) == 0) ? 4'hF : IB'($urandom);
      in_g = IB'($urandom);
      in_b = ($urandom_range(0, 3) == 0) ? 4'h9 : IB'($urandom);
      in_hs = ($urandom_range(0, 5) != 0);
      in_vs = ($urandom_range(0, 11) != 0);
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL video cyc %0d: got %h want %h", i, obs, expv); end
    end
  endtask

  task automatic test_sync_dither();
    logic [OB-1:0] want;
    int hs_seq[8]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    int r_seq[8]   = '{9, 9, 9, 9, 15, 15, 15, 15};
    int dith_w[8]  = '{3, 2, 2, 2, 3, 3, 3, 3};
    int trunc_w[8] = '{2, 2, 2, 2, 3, 3, 3, 3};
    in_hs = 1'b1; in_vs = 1'b1; in_r = '0; in_g = '0; in_b = '0;
    tick(); tick();
    in_hs = 1'b0; in_vs = 1'b0;
    tick();
    checks++;
    if ({frame_start, out_vs, out_hs} !== 3'b100) begin
      errors++; $display("FAIL sync_edge: got fs/vs/hs %b want 100", {frame_start, out_vs, out_hs});
    end
    in_r = 4'h9;
    tick();
    want = DITHER ? 2'd3 : 2'd2;
    checks++;
    if ({out_r, frame_start} !== {want, 1'b0}) begin
      errors++; $display("FAIL phase00: got r=%0d fs=%b want r=%0d fs=0", out_r, frame_start, want);
    end
    tick();
    checks++;
    if (out_r !== 2'd2) begin errors++; $display("FAIL phase01: got %0d want 2", out_r); end
    for (int i = 0; i < 8; i++) begin
      in_hs = hs_seq[i][0]; in_r = IB'(r_seq[i]);
      tick();
      want = OB'(DITHER ? dith_w[i] : trunc_w[i]);
      checks++;
      if (out_r !== want || obs !== expv) begin
        errors++; $display("FAIL grid step %0d: got r=%0d all=%h want r=%0d all=%h", i, out_r, obs, want, expv);
      end
    end
`ifndef BOARD_IO_DITHER_EN
    in_r = 4'hB; in_hs = 1'b1;
    tick();
    checks++;
    if ({out_r, out_hs} !== 3'b101) begin errors++; $display("FAIL trunc_B: got %b want 101", {out_r, out_hs}); end
`endif
    in_hs = 1'b1; in_vs = 1'b1;
    tick();
  endtask

  task automatic test_multi_channel();
    int np01, np2;
    logic hi0;
    btn_raw = '0;
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL mc_idle cyc %0d: got %h want %h", i, obs, expv); end
    end
    np01 = 0; np2 = 0; hi0 = 1'b0;
    for (int i = 0; i < 45; i++) begin
      btn_raw[2] = 1'b1;
      btn_raw[0] = ((i / 3) % 2) == 1;
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL mc cyc %0d: got %h want %h", i, obs, expv); end
      np01 += int'(btn_press[0] | btn_press[1]);
      np2  += int'(btn_press[2]);
      hi0  |= btn_level[0];
    end
    checks++;
    if ({hi0, btn_level[2]} !== 2'b01) begin errors++; $display("FAIL mc_levels: got %b want 01", {hi0, btn_level[2]}); end
    checks++;
    if (np01 != 0 || np2 != 1) begin errors++; $display("FAIL mc_press: got %0d/%0d want 0/1", np01, np2); end
  endtask

  task automatic test_reset_mid_debounce();
    int lat;
    btn_raw = '0;
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL mid_idle cyc %0d: got %h want %h", i, obs, expv); end
    end
    btn_raw = 3'b001;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL mid_reset: got %h want %h", obs, expv); end
    lat = -1;
    for (int i = 0; i < 14; i++) begin
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL mid_after cyc %0d: got %h want %h", i, obs, expv); end
      if (lat < 0 && btn_level[0] === 1'b1) lat = i + 1;
    end
    checks++;
    if (lat != int'(SS + DEB)) begin errors++; $display("FAIL mid_latency: got %0d want %0d", lat, SS + DEB); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_debounce();
    test_video_random();
    test_sync_dither();
    test_multi_channel();
    test_reset_mid_debounce();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
